display_owner_arbiter: RTL and testbench
========================================

# display_owner_arbiter

Round-robin arbiter that shares the board's six-digit seven-segment display datapath among several requesting client FSMs (lab FSM, shift-register view, switch monitor, and similar). Each client presents a 24-bit hex value and a request; the arbiter grants one owner at a time and forwards that owner's value to the seven-segment driver. A minimum-hold timer prevents preemption flicker. The block sits between the client FSMs and the seven-segment strobe/driver logic inside `top`.

## Interface
- `n_clients`, 4, number of requesters; legal range 2..8.
- `digits`, 6, hex digits per client value. Each value is `digits*4` bits wide.
- `hold_width`, 50_000_000, minimum clock cycles of ownership before another client can preempt; must be ≥1. Benches use small values.

- `clk`  input  1  system clock (50 MHz on board).
- `reset`  input  1  asynchronous, active-low reset.
- `req`  input  n_clients  per-client request; level-sensitive.
- `data`  input  n_clients*digits*4  flattened client values; client i occupies `[i*digits*4 +: digits*4]`.
- `grant`  output  n_clients  one-hot registered grant; all zero when idle.
- `owner`  output  $clog2(n_clients)  index of the current or last owner.
- `display_value`  output  digits*4  value forwarded to the seven-segment driver.
- `display_valid`  output  1  high while any grant is active.
- `switch_pulse`  output  1  one-cycle pulse on every cycle in which a new grant is issued.

## Operation
- The clock is `clk`. The reset is `reset`: asynchronous, active-low.
- Reset values: `grant`=0, `owner`=0, `display_value`=0, `display_valid`=0, `switch_pulse`=0, hold counter=0, state=IDLE, round-robin pointer `last`=n_clients-1, so client 0 has top priority first.
- Round-robin pick: the first requesting index scanning `last+1, last+2, …` modulo n_clients. On a grant, `last` is set to the new owner.
- The FSM has three states.
- **IDLE:** no grant. If any `req` is high, grant the pick, load counter=hold_width-1, set `switch_pulse`, and go to LOCKED. Otherwise stay in IDLE.
- **LOCKED** (counter running):
  - If `req[owner]`=0, the owner releases voluntarily. This takes effect immediately regardless of the counter.
  - On release, if another client is requesting, grant the pick (owner excluded) and reload the counter. If none is requesting, go to IDLE.
  - If `req[owner]`=1 and counter≠0, decrement the counter.
  - If `req[owner]`=1 and counter=0, evaluate exactly as OPEN in the same cycle.
- **OPEN** (hold expired):
  - If any other client is requesting, grant the pick with the owner excluded, reload the counter, and go to LOCKED.
  - Else if the owner still requests, stay in OPEN.
  - Else go to IDLE.
- Non-requesting clients are never granted.
- At most one `grant` bit is ever set.
- `owner` is retained through IDLE.
- `display_value` and `display_valid`:
  - While a grant is active, `display_value` is registered from the owner's `data` slice every cycle.
  - On a switch cycle, it loads the new owner's slice on the same edge that asserts the new `grant`.
  - In IDLE, `display_value` holds its last value and `display_valid`=0.
- Handoff between owners is direct (LOCKED→LOCKED or OPEN→LOCKED) with no idle gap; `switch_pulse` is 1 for that cycle.

## Timing
- Request to grant latency: 1 clock edge. A `req` sampled high at edge k gives `grant`/`switch_pulse`/`display_value` valid after edge k.
- Under continuous contention, each owner holds `grant` for exactly `hold_width` cycles.
- Voluntary release: `grant` drops, or moves to the next owner, on the first edge where `req[owner]`=0 is sampled.
- Data tracking: a `data` change of the owner appears on `display_value` one edge later.
- `switch_pulse` is exactly one cycle wide per new grant. It does not pulse while the same owner keeps the grant in OPEN.
- Reset mid-operation: all outputs clear asynchronously on `reset` falling. After `reset` rises, arbitration restarts from client 0 priority.

## Test plan
All scenarios use n_clients=4, digits=6, hold_width=3.
- **Single requester.** Reset, then `req`=0001 with data0=24'h123456 → after 1 edge `grant`=0001, `owner`=0, `display_value`=24'h123456, `display_valid`=1, `switch_pulse`=1 for one cycle. Grant is held indefinitely. Changing data0 to 24'hABCDEF shows on `display_value` 1 cycle later.
- **Full contention.** `req`=1111 from IDLE → `grant` sequence 0001, 0010, 0100, 1000, 0001…, each lasting exactly 3 cycles, with `switch_pulse` at each change.
- **Voluntary release.** Client 2 owns, `req`=0100→0001 one cycle after the grant → `grant`=0001 on the next edge, and the counter reloads.
- **Release to idle.** The owner drops its request with no others pending → `grant`=0, `display_valid`=0, `display_value` and `owner` hold.
- **Reset mid-operation.** Assert `reset`=0 while client 3 is in LOCKED → all outputs 0 immediately without a clock edge. Release reset with `req`=1010 → `grant`=0010 first.
- **hold_width=1.** `req`=0011 → `grant` alternates 0001/0010 every cycle.

Source files
------------

// File: rtl/display_owner_arbiter.sv
// display_owner_arbiter: round-robin owner selection for the shared
// seven-segment display datapath. One client owns the display at a time.
// A hold counter keeps other clients from preempting the owner until
// hold_width cycles have passed. The owner can release the display early
// by dropping its request.
module display_owner_arbiter #(
    parameter int n_clients  = 4,
    parameter int digits     = 6,
    parameter int hold_width = 50_000_000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [n_clients-1:0]           req,
    input  logic [n_clients*digits*4-1:0]  data,
    output logic [n_clients-1:0]           grant,
    output logic [$clog2(n_clients)-1:0]   owner,
    output logic [digits*4-1:0]            display_value,
    output logic                           display_valid,
    output logic                           switch_pulse
);

    localparam int IDX_W = $clog2(n_clients);
    localparam int VAL_W = digits * 4;
    localparam int CNT_W = (hold_width > 1) ? $clog2(hold_width) : 1;
    localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(hold_width - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1,
        OPEN   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [n_clients-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic                 switch_q, switch_d;
    logic [VAL_W-1:0]     disp_q, disp_d;
    logic                 valid_q, valid_d;

    logic [n_clients-1:0] owner_oh;
    logic [n_clients-1:0] others;
    logic                 own_req;
    logic [IDX_W-1:0]     pick_all;
    logic [IDX_W-1:0]     pick_oth;
    logic                 do_grant;
    logic                 go_idle;
    logic [IDX_W-1:0]     new_idx;

    // This function returns the first requesting index after base. The scan
    // runs base+1, base+2, ... and wraps modulo n_clients. If r is all zero,
    // it returns base. Callers gate the result with |r.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [n_clients-1:0] r,
                                                 input logic [IDX_W-1:0]     base);
        logic [IDX_W-1:0] p;
        int               best;
        int               d;
        p    = base;
        best = n_clients;
        for (int i = 0; i < n_clients; i++) begin
            d = i - int'(base) - 1;
            if (d < 0) d = d + n_clients;
            if (r[i] && (d < best)) begin
                best = d;
                p    = IDX_W'(i);
            end
        end
        return p;
    endfunction

    function automatic logic [n_clients-1:0] to_onehot(input logic [IDX_W-1:0] idx);
        logic [n_clients-1:0] oh;
        oh = '0;
        for (int i = 0; i < n_clients; i++) begin
            oh[i] = (idx == IDX_W'(i));
        end
        return oh;
    endfunction

    // Classify the requests relative to the current owner. While a grant is
    // active, last_q equals owner_q. So scanning from last_q with the owner
    // masked out gives the next client in round-robin order.
    always_comb begin
        owner_oh = to_onehot(owner_q);
        others   = req & ~owner_oh;
        own_req  = |(req & owner_oh);
        pick_all = rr_pick(req, last_q);
        pick_oth = rr_pick(others, last_q);
    end

    // Next-state logic: choose the owner, run the hold timer, and handle
    // handoff or release.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        last_d   = last_q;
        switch_d = 1'b0;
        do_grant = 1'b0;
        go_idle  = 1'b0;
        new_idx  = pick_all;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    do_grant = 1'b1;
                    new_idx  = pick_all;
                end
            end
            LOCKED: begin
                if (!own_req) begin
                    // An early release takes effect at once, whatever the counter holds.
                    if (|others) begin
                        do_grant = 1'b1;
                        new_idx  = pick_oth;
                    end else begin
                        go_idle = 1'b1;
                    end
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (|others) begin
                    // The hold has expired. In this same cycle, act as in OPEN.
                    do_grant = 1'b1;
                    new_idx  = pick_oth;
                end else begin
                    state_d = OPEN;
                end
            end
            OPEN: begin
                if (|others) begin
                    do_grant = 1'b1;
                    new_idx  = pick_oth;
                end else if (own_req) begin
                    state_d = OPEN;
                end else begin
                    go_idle = 1'b1;
                end
            end
            default: begin
                go_idle = 1'b1;
            end
        endcase

        if (do_grant) begin
            state_d  = LOCKED;
            grant_d  = to_onehot(new_idx);
            owner_d  = new_idx;
            last_d   = new_idx;
            cnt_d    = HOLD_INIT;
            switch_d = 1'b1;
        end

        if (go_idle) begin
            state_d = IDLE;
            grant_d = '0;
        end
    end

    // Display path. While a grant is active, it takes the data slice of the
    // next owner. So the new owner's value appears on the same edge as its
    // grant. In IDLE, it holds the last value.
    always_comb begin
        disp_d  = disp_q;
        valid_d = |grant_d;
        if (|grant_d) begin
            for (int i = 0; i < n_clients; i++) begin
                if (owner_d == IDX_W'(i)) disp_d = data[i*VAL_W +: VAL_W];
            end
        end
    end

    // State and output registers. The reset is asynchronous and active-low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            grant_q  <= '0;
            owner_q  <= '0;
            last_q   <= IDX_W'(n_clients - 1);
            switch_q <= 1'b0;
            disp_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            switch_q <= switch_d;
            disp_q   <= disp_d;
            valid_q  <= valid_d;
        end
    end

    assign grant         = grant_q;
    assign owner         = owner_q;
    assign display_value = disp_q;
    assign display_valid = valid_q;
    assign switch_pulse  = switch_q;

endmodule

// File: tb/tb_display_owner_arbiter.sv
// Directed bench for display_owner_arbiter. Instance a uses hold_width=3 and
// instance b uses hold_width=1. Both use four clients with six digits each.
module tb_display_owner_arbiter;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req_a = 4'b0000;
    logic [3:0]  req_b = 4'b0000;
    logic [95:0] data_a;
    logic [95:0] data_b;
    logic [3:0]  grant_a, grant_b;
    logic [1:0]  owner_a, owner_b;
    logic [23:0] dv_a, dv_b;
    logic        vld_a, vld_b, sw_a, sw_b;

    int nvec = 0;
    int nerr = 0;

    logic [23:0] dval [4];
    logic [3:0]  exp_g;
    int          exp_i;

    always #5 clk = ~clk;

    display_owner_arbiter #(.n_clients(4), .digits(6), .hold_width(3)) u_dut_a (
        .clk           (clk),
        .reset         (reset),
        .req           (req_a),
        .data          (data_a),
        .grant         (grant_a),
        .owner         (owner_a),
        .display_value (dv_a),
        .display_valid (vld_a),
        .switch_pulse  (sw_a)
    );

    display_owner_arbiter #(.n_clients(4), .digits(6), .hold_width(1)) u_dut_b (
        .clk           (clk),
        .reset         (reset),
        .req           (req_b),
        .data          (data_b),
        .grant         (grant_b),
        .owner         (owner_b),
        .display_value (dv_b),
        .display_valid (vld_b),
        .switch_pulse  (sw_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    initial begin
        dval[0] = 24'h111111;
        dval[1] = 24'h222222;
        dval[2] = 24'h333333;
        dval[3] = 24'h444444;
        data_a  = '0;
        data_a[23:0] = 24'h123456;
        data_b  = {24'h0000DD, 24'h0000CC, 24'h0000BB, 24'h0000AA};

        // The reset state is visible before any clock edge.
        #2;
        chk("rst_grant", 32'(grant_a), 32'h0);
        chk("rst_owner", 32'(owner_a), 32'h0);
        chk("rst_dv",    32'(dv_a),    32'h0);
        chk("rst_vld",   32'(vld_a),   32'h0);
        chk("rst_sw",    32'(sw_a),    32'h0);
        chk("rst_grantb", 32'(grant_b), 32'h0);
        step();
        reset = 1'b1;

        // Single requester
        req_a = 4'b0001;
        step();
        chk("single_grant", 32'(grant_a), 32'h1);
        chk("single_owner", 32'(owner_a), 32'h0);
        chk("single_dv",    32'(dv_a),    32'h123456);
        chk("single_vld",   32'(vld_a),   32'h1);
        chk("single_sw",    32'(sw_a),    32'h1);
        step();
        chk("single_sw_low", 32'(sw_a),   32'h0);
        chk("single_hold",   32'(grant_a), 32'h1);
        data_a[23:0] = 24'hABCDEF;
        step();
        chk("single_track", 32'(dv_a), 32'hABCDEF);
        step();
        step();
        chk("single_open_grant", 32'(grant_a), 32'h1);
        chk("single_open_sw",    32'(sw_a),    32'h0);
        chk("single_open_vld",   32'(vld_a),   32'h1);

        // The owner releases and no other client is waiting.
        req_a = 4'b0000;
        step();
        chk("idle_grant", 32'(grant_a), 32'h0);
        chk("idle_vld",   32'(vld_a),   32'h0);
        chk("idle_dv",    32'(dv_a),    32'hABCDEF);
        chk("idle_owner", 32'(owner_a), 32'h0);
        chk("idle_sw",    32'(sw_a),    32'h0);

        // Full contention: each owner holds for 3 cycles, in turn 0,1,2,3,0.
        do_reset();
        data_a = {dval[3], dval[2], dval[1], dval[0]};
        req_a  = 4'b1111;
        for (int c = 0; c < 13; c++) begin
            step();
            exp_i = (c / 3) % 4;
            exp_g = 4'b0001 << exp_i;
            chk($sformatf("cont_grant_c%0d", c), 32'(grant_a), 32'(exp_g));
            chk($sformatf("cont_sw_c%0d", c),    32'(sw_a),    ((c % 3) == 0) ? 32'h1 : 32'h0);
            chk($sformatf("cont_dv_c%0d", c),    32'(dv_a),    32'(dval[exp_i]));
        end

        // Voluntary release. Client 2 releases partway through its hold, and
        // the counter reloads for client 0.
        do_reset();
        req_a = 4'b0100;
        step();
        chk("vol_grant2", 32'(grant_a), 32'h4);
        chk("vol_owner2", 32'(owner_a), 32'h2);
        step();
        chk("vol_hold2",  32'(grant_a), 32'h4);
        req_a = 4'b0001;
        step();
        chk("vol_grant0", 32'(grant_a), 32'h1);
        chk("vol_sw0",    32'(sw_a),    32'h1);
        chk("vol_dv0",    32'(dv_a),    32'h111111);
        req_a = 4'b0011;
        step();
        chk("vol_reload1", 32'(grant_a), 32'h1);
        step();
        chk("vol_reload2", 32'(grant_a), 32'h1);
        step();
        chk("vol_handoff", 32'(grant_a), 32'h2);
        chk("vol_hand_sw", 32'(sw_a),    32'h1);
        chk("vol_hand_ow", 32'(owner_a), 32'h1);

        // Client 1 releases to IDLE. owner and display_value keep their values.
        req_a = 4'b0000;
        step();
        chk("rel_grant", 32'(grant_a), 32'h0);
        chk("rel_vld",   32'(vld_a),   32'h0);
        chk("rel_dv",    32'(dv_a),    32'h222222);
        chk("rel_owner", 32'(owner_a), 32'h1);

        // Reset while client 3 is LOCKED. All outputs clear without a clock edge.
        do_reset();
        req_a = 4'b1000;
        step();
        chk("mid_grant3", 32'(grant_a), 32'h8);
        chk("mid_owner3", 32'(owner_a), 32'h3);
        step();
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_grant", 32'(grant_a), 32'h0);
        chk("mid_rst_owner", 32'(owner_a), 32'h0);
        chk("mid_rst_dv",    32'(dv_a),    32'h0);
        chk("mid_rst_vld",   32'(vld_a),   32'h0);
        chk("mid_rst_sw",    32'(sw_a),    32'h0);
        req_a = 4'b1010;
        reset = 1'b1;
        step();
        chk("mid_restart_grant", 32'(grant_a), 32'h2);
        chk("mid_restart_owner", 32'(owner_a), 32'h1);
        chk("mid_restart_sw",    32'(sw_a),    32'h1);

        // With hold_width=1, two requesters swap the grant every cycle.
        do_reset();
        req_a = 4'b0000;
        req_b = 4'b0011;
        for (int c = 0; c < 6; c++) begin
            step();
            chk($sformatf("h1_grant_c%0d", c), 32'(grant_b), ((c % 2) == 0) ? 32'h1 : 32'h2);
            chk($sformatf("h1_sw_c%0d", c),    32'(sw_b),    32'h1);
            chk($sformatf("h1_dv_c%0d", c),    32'(dv_b),    ((c % 2) == 0) ? 32'hAA : 32'hBB);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
